// File: rtl/arm_defs.sv
// arm_defs: shared ALU command encodings and NZCV bit positions
package arm_defs;
  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_MVN = 4'b1001;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_SBC = 4'b0101;
  localparam logic [3:0] EXE_AND = 4'b0110;
  localparam logic [3:0] EXE_ORR = 4'b0111;
  localparam logic [3:0] EXE_EOR = 4'b1000;
  localparam int N_BIT = 3;
  localparam int Z_BIT = 2;
  localparam int C_BIT = 1;
  localparam int V_BIT = 0;
endpackage

// File: rtl/exe_alu.sv
// exe_alu: combinational ALU producing result and NZCV
module exe_alu
  import arm_defs::*;
#(
  parameter int DW = 32
) (
  input  logic [DW-1:0] val1,
  input  logic [DW-1:0] val2,
  input  logic [3:0]    exe_cmd,
  input  logic          c_in,
  input  logic          v_in,
  output logic [DW-1:0] result,
  output logic [3:0]    nzcv
);
  logic          arith;
  logic          sub;
  logic          cin;
  logic [DW-1:0] b;
  logic [DW:0]   sum;
  always_comb begin
    arith = exe_cmd inside {EXE_ADD, EXE_ADC, EXE_SUB, EXE_SBC};
    sub   = exe_cmd inside {EXE_SUB, EXE_SBC};
    cin   = exe_cmd == EXE_SUB ? 1'b1 : exe_cmd == EXE_ADD ? 1'b0 : c_in;
    b     = sub ? ~val2 : val2;
    sum   = {1'b0, val1} + {1'b0, b} + {{DW{1'b0}}, cin};
    result = arith                ? sum[DW-1:0] :
             exe_cmd == EXE_MOV   ? val2 :
             exe_cmd == EXE_MVN   ? ~val2 :
             exe_cmd == EXE_AND   ? val1 & val2 :
             exe_cmd == EXE_ORR   ? val1 | val2 :
             exe_cmd == EXE_EOR   ? val1 ^ val2 : '0;
    nzcv[N_BIT] = result[DW-1];
    nzcv[Z_BIT] = result == '0;
    nzcv[C_BIT] = arith ? sum[DW] : c_in;
    nzcv[V_BIT] = arith ? (val1[DW-1] == b[DW-1]) && (sum[DW-1] != val1[DW-1]) : v_in;
  end
endmodule

// File: rtl/exe_stage.sv
// exe_stage: execute stage with status register, branch adder and EX/MEM register
module exe_stage
  import arm_defs::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          freeze,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [3:0]    exe_cmd,
  input  logic          s_bit,
  input  logic          b_bit,
  input  logic          wb_en,
  input  logic          mem_r_en,
  input  logic          mem_w_en,
  input  logic [DW-1:0] val1,
  input  logic [DW-1:0] val2,
  input  logic [DW-1:0] val_rm,
  input  logic [3:0]    dest,
  input  logic [DW-1:0] pc,
  input  logic [23:0]   imm24,
  output logic [3:0]    status,
  output logic          branch_taken,
  output logic [DW-1:0] br_addr,
  output logic          mem_valid,
  output logic [DW-1:0] mem_alu_res,
  output logic [DW-1:0] mem_val_rm,
  output logic [3:0]    mem_dest,
  output logic          mem_wb_en,
  output logic          mem_r_en_o,
  output logic          mem_w_en_o
);
  logic [DW-1:0] alu_res;
  logic [3:0]    alu_nzcv;
  logic          live;
  exe_alu #(.DW(DW)) u_alu (
    .val1    (val1),
    .val2    (val2),
    .exe_cmd (exe_cmd),
    .c_in    (status[C_BIT]),
    .v_in    (status[V_BIT]),
    .result  (alu_res),
    .nzcv    (alu_nzcv)
  );
  assign live         = in_valid & ~flush;
  assign branch_taken = live & b_bit & ~freeze;
  assign br_addr      = pc + {{(DW-26){imm24[23]}}, imm24, 2'b00};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) status <= '0;
    else if (live && s_bit && !freeze) status <= alu_nzcv;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_valid   <= 1'b0;
      mem_alu_res <= '0;
      mem_val_rm  <= '0;
      mem_dest    <= '0;
      mem_wb_en   <= 1'b0;
      mem_r_en_o  <= 1'b0;
      mem_w_en_o  <= 1'b0;
    end else if (!freeze) begin
      mem_valid   <= live;
      mem_alu_res <= alu_res;
      mem_val_rm  <= val_rm;
      mem_dest    <= dest;
      mem_wb_en   <= wb_en & live;
      mem_r_en_o  <= mem_r_en & live;
      mem_w_en_o  <= mem_w_en & live;
    end
  end
endmodule

// File: tb/tb_exe_stage.sv
// tb_exe_stage: directed vectors for exe_stage with hand-computed expectations
module tb_exe_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        freeze = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  exe_cmd = '0;
  logic        s_bit = 1'b0;
  logic        b_bit = 1'b0;
  logic        wb_en = 1'b0;
  logic        mem_r_en = 1'b0;
  logic        mem_w_en = 1'b0;
  logic [31:0] val1 = '0;
  logic [31:0] val2 = '0;
  logic [31:0] val_rm = '0;
  logic [3:0]  dest = '0;
  logic [31:0] pc = '0;
  logic [23:0] imm24 = '0;
  logic [3:0]  status;
  logic        branch_taken;
  logic [31:0] br_addr;
  logic        mem_valid;
  logic [31:0] mem_alu_res;
  logic [31:0] mem_val_rm;
  logic [3:0]  mem_dest;
  logic        mem_wb_en;
  logic        mem_r_en_o;
  logic        mem_w_en_o;
  int          n_tests = 0;
  int          n_fail = 0;
  exe_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .freeze       (freeze),
    .flush        (flush),
    .in_valid     (in_valid),
    .exe_cmd      (exe_cmd),
    .s_bit        (s_bit),
    .b_bit        (b_bit),
    .wb_en        (wb_en),
    .mem_r_en     (mem_r_en),
    .mem_w_en     (mem_w_en),
    .val1         (val1),
    .val2         (val2),
    .val_rm       (val_rm),
    .dest         (dest),
    .pc           (pc),
    .imm24        (imm24),
    .status       (status),
    .branch_taken (branch_taken),
    .br_addr      (br_addr),
    .mem_valid    (mem_valid),
    .mem_alu_res  (mem_alu_res),
    .mem_val_rm   (mem_val_rm),
    .mem_dest     (mem_dest),
    .mem_wb_en    (mem_wb_en),
    .mem_r_en_o   (mem_r_en_o),
    .mem_w_en_o   (mem_w_en_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic op(input logic [3:0] c, input logic s, input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1;
    exe_cmd  = c;
    s_bit    = s;
    val1     = a;
    val2     = b;
    wb_en    = 1'b1;
  endtask
  initial begin
    step();
    step();
    chk("rst_status", 32'(status), 32'h0);
    chk("rst_valid", 32'(mem_valid), 32'h0);
    chk("rst_res", mem_alu_res, 32'h0);
    #3 rst_n = 1'b1;
    step();
    chk("idle_valid", 32'(mem_valid), 32'h0);
    op(4'b0010, 1'b1, 32'h7FFF_FFFF, 32'h1);
    dest = 4'd3; val_rm = 32'hCAFE; mem_w_en = 1'b1;
    step();
    chk("add_res", mem_alu_res, 32'h8000_0000);
    chk("add_nzcv", 32'(status), 32'b1001);
    chk("add_valid", 32'(mem_valid), 32'h1);
    chk("add_dest", 32'(mem_dest), 32'd3);
    chk("add_rm", mem_val_rm, 32'hCAFE);
    chk("add_wen", 32'(mem_w_en_o), 32'h1);
    mem_w_en = 1'b0;
    op(4'b1000, 1'b1, 32'h5, 32'h5);
    step();
    chk("eor_res", mem_alu_res, 32'h0);
    chk("eor_nzcv_keep_v", 32'(status), 32'b0101);
    op(4'b0100, 1'b1, 32'h5, 32'h5);
    step();
    chk("sub_res", mem_alu_res, 32'h0);
    chk("sub_nzcv", 32'(status), 32'b0110);
    op(4'b1001, 1'b1, 32'h0, 32'h0);
    step();
    chk("mvn_res", mem_alu_res, 32'hFFFF_FFFF);
    chk("mvn_nzcv_keep_c", 32'(status), 32'b1010);
    op(4'b1111, 1'b1, 32'h9, 32'h9);
    step();
    chk("unk_res", mem_alu_res, 32'h0);
    chk("unk_nzcv", 32'(status), 32'b0110);
    op(4'b0101, 1'b1, 32'h3, 32'h1);
    step();
    chk("sbc_res", mem_alu_res, 32'h2);
    chk("sbc_nzcv", 32'(status), 32'b0010);
    op(4'b0011, 1'b1, 32'h1, 32'h2);
    step();
    chk("adc_res", mem_alu_res, 32'h4);
    chk("adc_nzcv", 32'(status), 32'b0000);
    op(4'b0110, 1'b0, 32'hF0F0, 32'hFF00);
    step();
    chk("and_res", mem_alu_res, 32'hF000);
    op(4'b0111, 1'b0, 32'hF0F0, 32'hFF00);
    step();
    chk("orr_res", mem_alu_res, 32'hFFF0);
    op(4'b0001, 1'b0, 32'hFFFF, 32'h1234);
    step();
    chk("mov_res", mem_alu_res, 32'h1234);
    op(4'b0001, 1'b1, 32'h0, 32'h8000_0000);
    in_valid = 1'b0;
    step();
    chk("inv_status", 32'(status), 32'b0000);
    chk("inv_valid", 32'(mem_valid), 32'h0);
    chk("inv_wb", 32'(mem_wb_en), 32'h0);
    op(4'b0010, 1'b1, 32'h1, 32'h2);
    dest = 4'd7;
    step();
    chk("frz_pre_res", mem_alu_res, 32'h3);
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      op(4'b0100, 1'b1, 32'(i), 32'h1);
      dest = 4'(i + 9);
      b_bit = 1'b1;
      #1 chk("frz_no_branch", 32'(branch_taken), 32'h0);
      step();
      chk("frz_res", mem_alu_res, 32'h3);
      chk("frz_dest", 32'(mem_dest), 32'd7);
      chk("frz_status", 32'(status), 32'b0000);
    end
    b_bit = 1'b0;
    freeze = 1'b0;
    op(4'b0100, 1'b1, 32'h0, 32'h1);
    step();
    chk("unfrz_res", mem_alu_res, 32'hFFFF_FFFF);
    chk("unfrz_nzcv", 32'(status), 32'b1000);
    chk("unfrz_dest", 32'(mem_dest), 32'd11);
    op(4'b0010, 1'b0, 32'h0, 32'h0);
    wb_en = 1'b0; b_bit = 1'b1; pc = 32'h100; imm24 = 24'hFFFFFE;
    #1;
    chk("br_addr", br_addr, 32'hF8);
    chk("br_taken", 32'(branch_taken), 32'h1);
    step();
    op(4'b0010, 1'b1, 32'h1, 32'h1);
    flush = 1'b1;
    #1 chk("br_flush_no_take", 32'(branch_taken), 32'h0);
    step();
    chk("flush_valid", 32'(mem_valid), 32'h0);
    chk("flush_wb", 32'(mem_wb_en), 32'h0);
    chk("flush_status", 32'(status), 32'b1000);
    flush = 1'b0; b_bit = 1'b0;
    op(4'b0010, 1'b1, 32'h0, 32'h0);
    step();
    chk("zero_nzcv", 32'(status), 32'b0100);
    op(4'b0100, 1'b1, 32'h0, 32'h1);
    wb_en = 1'b0; flush = 1'b1;
    step();
    chk("cmp_flush_status", 32'(status), 32'b0100);
    chk("cmp_flush_wb", 32'(mem_wb_en), 32'h0);
    flush = 1'b0;
    op(4'b0010, 1'b0, 32'h10, 32'h20);
    mem_r_en = 1'b1;
    step();
    chk("ldr_addr", mem_alu_res, 32'h30);
    chk("ldr_ren", 32'(mem_r_en_o), 32'h1);
    freeze = 1'b1; flush = 1'b1;
    step();
    chk("frz_flush_valid", 32'(mem_valid), 32'h1);
    chk("frz_flush_ren", 32'(mem_r_en_o), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_status", 32'(status), 32'h0);
    chk("midrst_valid", 32'(mem_valid), 32'h0);
    chk("midrst_res", mem_alu_res, 32'h0);
    chk("midrst_ren", 32'(mem_r_en_o), 32'h0);
    rst_n = 1'b1;
    freeze = 1'b0; flush = 1'b0; in_valid = 1'b0; mem_r_en = 1'b0;
    step();
    chk("post_rst_valid", 32'(mem_valid), 32'h0);
    chk("post_rst_status", 32'(status), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
